// File: rtl/sensor_request_if.sv
// Bundle of sensor inputs, phase-FSM handshake and debug outputs for sensor_request.
interface sensor_request_if;
  logic       car_sensor_raw;
  logic       ped_button_raw;
  logic [1:0] phase_ack;
  logic [1:0] go_control;
  logic       car_level;
  logic [7:0] car_count;

  modport master (
    output car_sensor_raw, ped_button_raw, phase_ack,
    input  go_control, car_level, car_count
  );

  modport slave (
    input  car_sensor_raw, ped_button_raw, phase_ack,
    output go_control, car_level, car_count
  );
endinterface

// File: rtl/sensor_request.sv
// Synchronizes and debounces car/pedestrian inputs and latches requests until acked.
// Pedestrian path is built only when SENSOR_REQUEST_PED_EN is defined.
module sensor_request #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input logic        clk,
  input logic        reset,
  sensor_request_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       car_sync_q;
  logic [CNT_W-1:0] car_cnt_q, car_cnt_d;
  logic             car_lvl_q, car_lvl_d;
  logic             car_prev_q;
  logic             car_rise;
  logic [7:0]       car_count_q, car_count_d;
  logic [1:0]       go_q, go_d;

  // Level toggles on the cycle the mismatch count would reach DEBOUNCE_CYCLES
  always_comb begin
    car_cnt_d = car_cnt_q;
    car_lvl_d = car_lvl_q;
    if (car_sync_q[1] == car_lvl_q) begin
      car_cnt_d = '0;
    end else if (car_cnt_q == CNT_MAX) begin
      car_cnt_d = '0;
      car_lvl_d = ~car_lvl_q;
    end else begin
      car_cnt_d = car_cnt_q + CNT_W'(1);
    end
  end

  assign car_rise = car_lvl_q & ~car_prev_q;

  // Ack and arrival in the same cycle leaves exactly one arrival counted
  always_comb begin
    car_count_d = car_count_q;
    if (bus.phase_ack[0]) begin
      car_count_d = car_rise ? 8'd1 : 8'd0;
    end else if (car_rise && car_count_q != 8'hFF) begin
      car_count_d = car_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      car_sync_q  <= '0;
      car_cnt_q   <= '0;
      car_lvl_q   <= 1'b0;
      car_prev_q  <= 1'b0;
      car_count_q <= '0;
    end else begin
      car_sync_q  <= {car_sync_q[0], bus.car_sensor_raw};
      car_cnt_q   <= car_cnt_d;
      car_lvl_q   <= car_lvl_d;
      car_prev_q  <= car_lvl_q;
      car_count_q <= car_count_d;
    end
  end

`ifdef SENSOR_REQUEST_PED_EN
  logic [1:0]       ped_sync_q;
  logic [CNT_W-1:0] ped_cnt_q, ped_cnt_d;
  logic             ped_lvl_q, ped_lvl_d;
  logic             ped_prev_q;
  logic             ped_rise;

  always_comb begin
    ped_cnt_d = ped_cnt_q;
    ped_lvl_d = ped_lvl_q;
    if (ped_sync_q[1] == ped_lvl_q) begin
      ped_cnt_d = '0;
    end else if (ped_cnt_q == CNT_MAX) begin
      ped_cnt_d = '0;
      ped_lvl_d = ~ped_lvl_q;
    end else begin
      ped_cnt_d = ped_cnt_q + CNT_W'(1);
    end
  end

  assign ped_rise = ped_lvl_q & ~ped_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ped_sync_q <= '0;
      ped_cnt_q  <= '0;
      ped_lvl_q  <= 1'b0;
      ped_prev_q <= 1'b0;
    end else begin
      ped_sync_q <= {ped_sync_q[0], bus.ped_button_raw};
      ped_cnt_q  <= ped_cnt_d;
      ped_lvl_q  <= ped_lvl_d;
      ped_prev_q <= ped_lvl_q;
    end
  end
`else
  logic unused_ped;
  assign unused_ped = bus.ped_button_raw ^ bus.phase_ack[1];
`endif

  // A new rising edge wins over a coincident ack
  always_comb begin
    go_d[0] = car_rise | (go_q[0] & ~bus.phase_ack[0]);
`ifdef SENSOR_REQUEST_PED_EN
    go_d[1] = ped_rise | (go_q[1] & ~bus.phase_ack[1]);
`else
    go_d[1] = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      go_q <= '0;
    end else begin
      go_q <= go_d;
    end
  end

  assign bus.go_control = go_q;
  assign bus.car_level  = car_lvl_q;
  assign bus.car_count  = car_count_q;

endmodule

// File: tb/tb_sensor_request.sv
// Directed self-checking bench for sensor_request with DEBOUNCE_CYCLES=4.
module tb_sensor_request;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  sensor_request_if bus ();

  sensor_request #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; inputs are driven and outputs sampled 1 ns after the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if (bus.go_control !== 2'b00 || bus.car_level !== 1'b0 || bus.car_count !== 8'd0) begin
      n_err++;
      $display("FAIL %s: go=%b lvl=%b cnt=%0d, required go=00 lvl=0 cnt=0",
               tag, bus.go_control, bus.car_level, bus.car_count);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.car_sensor_raw = 1'b0;
    bus.ped_button_raw = 1'b0;
    bus.phase_ack = 2'b00;
    tick(3);
    check_all_zero("reset_state");
    reset = 1'b0;
    tick(2);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_latency;
    bus.car_sensor_raw = 1'b1;
    tick(5);
    n_cmp++;
    if (bus.car_level !== 1'b0) begin n_err++; $display("FAIL lvl_edge5: got %b required 0", bus.car_level); end
    tick(1);
    n_cmp++;
    if (bus.car_level !== 1'b1 || bus.go_control[0] !== 1'b0) begin
      n_err++; $display("FAIL edge6: lvl=%b go0=%b required lvl=1 go0=0", bus.car_level, bus.go_control[0]);
    end
    tick(1);
    n_cmp++;
    if (bus.go_control[0] !== 1'b1 || bus.car_count !== 8'd1) begin
      n_err++; $display("FAIL edge7: go0=%b cnt=%0d required go0=1 cnt=1", bus.go_control[0], bus.car_count);
    end
  endtask

  task automatic test_ack;
    bus.phase_ack = 2'b01;
    tick(1);
    bus.phase_ack = 2'b00;
    n_cmp++;
    if (bus.go_control[0] !== 1'b0 || bus.car_count !== 8'd0) begin
      n_err++; $display("FAIL ack_clear: go0=%b cnt=%0d required go0=0 cnt=0", bus.go_control[0], bus.car_count);
    end
    tick(2);
    bus.phase_ack = 2'b01;
    tick(1);
    bus.phase_ack = 2'b00;
    tick(1);
    n_cmp++;
    if (bus.go_control[0] !== 1'b0 || bus.car_count !== 8'd0 || bus.car_level !== 1'b1) begin
      n_err++; $display("FAIL stray_ack: go0=%b cnt=%0d lvl=%b required go0=0 cnt=0 lvl=1",
                        bus.go_control[0], bus.car_count, bus.car_level);
    end
  endtask

  task automatic test_glitch;
    int bad;
    bus.car_sensor_raw = 1'b0;
    tick(8);
    bus.car_sensor_raw = 1'b1;
    tick(3);
    bus.car_sensor_raw = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.car_level !== 1'b0 || bus.go_control[0] !== 1'b0 || bus.car_count !== 8'd0) bad++;
      tick(1);
    end
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL short_pulse: %0d bad cycles required 0", bad); end
  endtask

  task automatic test_simultaneous;
    bus.car_sensor_raw = 1'b1;
    tick(7);
    bus.car_sensor_raw = 1'b0;
    tick(8);
    n_cmp++;
    if (bus.car_level !== 1'b0 || bus.go_control[0] !== 1'b1 || bus.car_count !== 8'd1) begin
      n_err++; $display("FAIL fall_no_effect: lvl=%b go0=%b cnt=%0d required lvl=0 go0=1 cnt=1",
                        bus.car_level, bus.go_control[0], bus.car_count);
    end
    bus.car_sensor_raw = 1'b1;
    tick(6);
    bus.phase_ack = 2'b01;
    tick(1);
    bus.phase_ack = 2'b00;
    n_cmp++;
    if (bus.go_control[0] !== 1'b1 || bus.car_count !== 8'd1) begin
      n_err++; $display("FAIL set_wins: go0=%b cnt=%0d required go0=1 cnt=1", bus.go_control[0], bus.car_count);
    end
  endtask

  task automatic test_saturate;
    bus.car_sensor_raw = 1'b0;
    bus.phase_ack = 2'b01;
    tick(1);
    bus.phase_ack = 2'b00;
    tick(8);
    for (int i = 1; i <= 300; i++) begin
      bus.car_sensor_raw = 1'b1;
      tick(7);
      bus.car_sensor_raw = 1'b0;
      tick(7);
      if (i == 10) begin
        n_cmp++;
        if (bus.car_count !== 8'd10) begin n_err++; $display("FAIL count10: got %0d required 10", bus.car_count); end
      end
    end
    n_cmp++;
    if (bus.car_count !== 8'd255 || bus.go_control[0] !== 1'b1) begin
      n_err++; $display("FAIL saturate: cnt=%0d go0=%b required cnt=255 go0=1", bus.car_count, bus.go_control[0]);
    end
  endtask

  task automatic test_ped;
`ifdef SENSOR_REQUEST_PED_EN
    bus.phase_ack = 2'b01;
    tick(1);
    bus.phase_ack = 2'b00;
    bus.ped_button_raw = 1'b1;
    bus.car_sensor_raw = 1'b1;
    tick(6);
    n_cmp++;
    if (bus.go_control !== 2'b00) begin n_err++; $display("FAIL ped_edge6: go=%b required 00", bus.go_control); end
    tick(1);
    n_cmp++;
    if (bus.go_control !== 2'b11) begin n_err++; $display("FAIL both_set: go=%b required 11", bus.go_control); end
    bus.phase_ack = 2'b10;
    tick(1);
    bus.phase_ack = 2'b00;
    n_cmp++;
    if (bus.go_control !== 2'b01) begin n_err++; $display("FAIL ped_ack: go=%b required 01", bus.go_control); end
    bus.phase_ack = 2'b11;
    tick(1);
    bus.phase_ack = 2'b00;
    n_cmp++;
    if (bus.go_control !== 2'b00) begin n_err++; $display("FAIL both_ack: go=%b required 00", bus.go_control); end
    bus.ped_button_raw = 1'b0;
    bus.car_sensor_raw = 1'b0;
    tick(8);
    bus.ped_button_raw = 1'b1;
    bus.car_sensor_raw = 1'b1;
    tick(7);
`else
    int bad;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      bus.ped_button_raw = (i % 10) < 7;
      bus.phase_ack = {i[0], 1'b0};
      tick(1);
      if (bus.go_control[1] !== 1'b0) bad++;
    end
    bus.phase_ack = 2'b00;
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL ped_disabled: %0d cycles with go1=1 required 0", bad); end
    bus.car_sensor_raw = 1'b1;
    tick(7);
`endif
  endtask

  task automatic test_reset_pending;
    reset = 1'b1;
    tick(1);
    check_all_zero("reset_pending");
    reset = 1'b0;
    bus.ped_button_raw = 1'b0;
    bus.car_sensor_raw = 1'b0;
    tick(8);
    bus.car_sensor_raw = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(1);
    check_all_zero("reset_mid_debounce");
    reset = 1'b0;
    tick(6);
    n_cmp++;
    if (bus.car_level !== 1'b1 || bus.go_control[0] !== 1'b0) begin
      n_err++; $display("FAIL redebounce_edge6: lvl=%b go0=%b required lvl=1 go0=0", bus.car_level, bus.go_control[0]);
    end
    tick(1);
    n_cmp++;
    if (bus.go_control[0] !== 1'b1 || bus.car_count !== 8'd1) begin
      n_err++; $display("FAIL redebounce_edge7: go0=%b cnt=%0d required go0=1 cnt=1", bus.go_control[0], bus.car_count);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_latency();
    test_ack();
    test_glitch();
    test_simultaneous();
    test_saturate();
    test_ped();
    test_reset_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
